// File: rtl/arb_pkg.sv
// Shared types and defaults for the register-bank write-port arbiter.
// Provides the arbiter state enum and round-robin pointer arithmetic.
package arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF    = 4;
    localparam int DW_DEF      = 16;
    localparam int AW_DEF      = 3;
    localparam int MAXLOCK_DEF = 8;

    function automatic int unsigned ptr_next(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_if.sv
// Requester/bank bundle around the shared register-bank write port.
// master = requester side, slave = arbiter side.
interface wr_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
);

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] waddr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    gnt;
    logic               we;
    logic [AW-1:0]      wa;
    logic [DW-1:0]      wd;
    logic               busy;

    modport master (
        output req, waddr, wdata, lock,
        input  gnt, we, wa, wd, busy
    );

    modport slave (
        input  req, waddr, wdata, lock,
        output gnt, we, wa, wd, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set req at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [PW-1:0]     off;
    logic [PW:0]       sum;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[NREQ-1:0];
        off = '0;
        any = |req;
        // downward scan so the lowest rotated offset wins
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = PW'(k);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(NREQ))
            idx = PW'(sum - (PW+1)'(NREQ));
        else
            idx = PW'(sum);
        gnt = '0;
        gnt[idx] = any;
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter for the register-bank write port, registered write.
// ARB_LOCK_EN enables lock mode (LOCKED state, owner, lock_cnt, busy).
module wr_port_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int MAXLOCK = MAXLOCK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    wr_port_arbiter_if.slave  bus
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   pick_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   g_idx;
    logic            g_any;

    logic            we;
    logic [AW-1:0]   wa;
    logic [DW-1:0]   wd;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req (bus.req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef ARB_LOCK_EN

    localparam int CW = $clog2(MAXLOCK + 1);

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [PW-1:0] owner;
    logic [PW-1:0] owner_nxt;
    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          hold;
    logic          take_pick;
    logic          busy;

    // on release the search restarts just past the owner
    always_comb begin
        pick_ptr = ptr;
        if (state == LOCKED)
            pick_ptr = PW'(ptr_next(32'(owner), NREQ));
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = lock_cnt;
        ptr_nxt   = ptr;
        g_idx     = pick_idx;
        g_any     = 1'b0;
        take_pick = 1'b0;
        hold      = bus.req[owner] & bus.lock[owner];
        cnt_inc   = lock_cnt + 1'b1;
        unique case (state)
            IDLE: begin
                take_pick = 1'b1;
            end
            LOCKED: begin
                if (hold) begin
                    g_idx   = owner;
                    g_any   = 1'b1;
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CW'(MAXLOCK)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        ptr_nxt   = PW'(ptr_next(32'(owner), NREQ));
                    end
                end else begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    ptr_nxt   = pick_ptr;
                    take_pick = 1'b1;
                end
            end
        endcase
        // a same-cycle round-robin winner advances ptr past itself
        if (take_pick && pick_any) begin
            g_any   = 1'b1;
            g_idx   = pick_idx;
            ptr_nxt = PW'(ptr_next(32'(pick_idx), NREQ));
            if (bus.lock[pick_idx]) begin
                state_nxt = LOCKED;
                owner_nxt = pick_idx;
                cnt_nxt   = CW'(1);
            end
        end
        g_any = g_any & rst;
        gnt = '0;
        gnt[g_idx] = g_any;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= '0;
            lock_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            lock_cnt <= cnt_nxt;
            busy     <= (state_nxt == LOCKED);
        end
    end

    assign bus.busy = busy;

`else

    logic unused_lock;

    assign pick_ptr    = ptr;
    assign unused_lock = ^bus.lock;

    always_comb begin
        g_idx   = pick_idx;
        g_any   = pick_any & rst;
        ptr_nxt = ptr;
        if (pick_any)
            ptr_nxt = PW'(ptr_next(32'(pick_idx), NREQ));
        gnt = '0;
        gnt[g_idx] = g_any;
    end

    assign bus.busy = 1'b0;

`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            we  <= 1'b0;
            wa  <= '0;
            wd  <= '0;
        end else begin
            ptr <= ptr_nxt;
            we  <= g_any;
            if (g_any) begin
                wa <= bus.waddr[32'(g_idx)*AW +: AW];
                wd <= bus.wdata[32'(g_idx)*DW +: DW];
            end
        end
    end

    assign bus.gnt = gnt;
    assign bus.we  = we;
    assign bus.wa  = wa;
    assign bus.wd  = wd;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Directed bench for wr_port_arbiter with a write scoreboard.
// Lock-mode steps are compiled in when ARB_LOCK_EN is defined.
module tb_wr_port_arbiter;
    import arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int AW      = 3;
    localparam int MAXLOCK = 8;
`ifdef ARB_LOCK_EN
    localparam logic LK = 1'b1;
`else
    localparam logic LK = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] tag;
    wr_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wr_port_arbiter_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    wr_port_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .AW      (AW),
        .MAXLOCK (MAXLOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic load_data();
        for (int i = 0; i < NREQ; i++) begin
            bus.waddr[i*AW +: AW] = AW'(i) ^ tag[AW-1:0];
            bus.wdata[i*DW +: DW] = {tag, 8'(i)};
        end
    endtask

    // one clock: drive, check gnt mid-cycle, check registered write after edge
    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic [NREQ-1:0] eg, input logic eb);
        wr_t e;
        bus.req  = r;
        bus.lock = l;
        load_data();
        #3;
        check("gnt", 32'(bus.gnt), 32'(eg));
        for (int i = 0; i < NREQ; i++) begin
            if (eg[i]) begin
                e.a = AW'(i) ^ tag[AW-1:0];
                e.d = {tag, 8'(i)};
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("we", 32'(bus.we), 32'(1));
            check("wa", 32'(bus.wa), 32'(e.a));
            check("wd", 32'(bus.wd), 32'(e.d));
        end else begin
            check("we_idle", 32'(bus.we), 32'(0));
        end
        check("busy", 32'(bus.busy), 32'(eb));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        tag      = 8'hA0;
        bus.req  = '1;
        bus.lock = '0;
        load_data();
        @(posedge clk);
        #3;
        check("rst_gnt", 32'(bus.gnt), 32'(0));
        check("rst_we", 32'(bus.we), 32'(0));
        check("rst_wa", 32'(bus.wa), 32'(0));
        check("rst_wd", 32'(bus.wd), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 8; k++)
            cyc(4'hF, 4'h0, 4'(1 << (k % 4)), 1'b0);

        tag = 8'hB5;
        cyc(4'b0100, 4'h0, 4'b0100, 1'b0);
        cyc(4'b0101, 4'h0, 4'b0001, 1'b0);
        cyc(4'b0101, 4'h0, 4'b0100, 1'b0);
        cyc(4'b0101, 4'h0, 4'b0001, 1'b0);
        cyc(4'b0000, 4'h0, 4'b0000, 1'b0);
        cyc(4'b1001, 4'h0, 4'b1000, 1'b0);
        cyc(4'b1001, 4'h0, 4'b0001, 1'b0);

        tag = 8'h3C;
`ifdef ARB_LOCK_EN
        for (int n = 1; n <= MAXLOCK; n++)
            cyc(4'hF, 4'b0010, 4'b0010, logic'(n < MAXLOCK));
        cyc(4'hF, 4'b0010, 4'b0100, 1'b0);
        tag = 8'h5E;
        for (int n = 0; n < 3; n++)
            cyc(4'b1001, 4'b1000, 4'b1000, 1'b1);
        cyc(4'b1001, 4'b0000, 4'b0001, 1'b0);
`else
        cyc(4'b0011, 4'b0011, 4'b0010, 1'b0);
        cyc(4'b0011, 4'b0011, 4'b0001, 1'b0);
        cyc(4'b0011, 4'b0011, 4'b0010, 1'b0);
`endif

        do_reset();
        tag = 8'h71;
        cyc(4'b0010, 4'b0010, 4'b0010, LK);
        cyc(4'b0010, 4'b0010, 4'b0010, LK);
        #3;
        check("gnt_pre_rst", 32'(bus.gnt), 32'(4'b0010));
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_we", 32'(bus.we), 32'(0));
        check("mid_rst_wa", 32'(bus.wa), 32'(0));
        check("mid_rst_wd", 32'(bus.wd), 32'(0));
        check("mid_rst_busy", 32'(bus.busy), 32'(0));
        check("mid_rst_gnt", 32'(bus.gnt), 32'(0));
        @(posedge clk);
        #1;
        check("rst_hold_we", 32'(bus.we), 32'(0));
        rst = 1'b1;
        tag = 8'h92;
        cyc(4'hF, 4'h0, 4'b0001, 1'b0);
        cyc(4'hF, 4'h0, 4'b0010, 1'b0);
        check("sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
